// File: rtl/dds_wavegen_if.sv
// Configuration and sample bus of the DDS waveform generator.
// sync_in exists only when DDS_PHASE_SYNC_EN is defined.
interface dds_wavegen_if #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 8
);
  logic               en;
  logic               cfg_load;
  logic [2:0]         cfg_mode;
  logic [PHASE_W-1:0] cfg_tune;
  logic [ADDR_W-1:0]  cfg_duty;
  logic [OUT_W-1:0]   cfg_amp;
  logic [ADDR_W-1:0]  cfg_phase;
  logic               wrap;
  logic [OUT_W-1:0]   pout;
  logic               pout_valid;
`ifdef DDS_PHASE_SYNC_EN
  logic               sync_in;
`endif

  modport master (
`ifdef DDS_PHASE_SYNC_EN
    output sync_in,
`endif
    output en, cfg_load, cfg_mode, cfg_tune, cfg_duty, cfg_amp, cfg_phase,
    input  wrap, pout, pout_valid
  );

  modport slave (
`ifdef DDS_PHASE_SYNC_EN
    input  sync_in,
`endif
    input  en, cfg_load, cfg_mode, cfg_tune, cfg_duty, cfg_amp, cfg_phase,
    output wrap, pout, pout_valid
  );
endinterface

// File: rtl/dds_wavegen.sv
// Phase-accumulator DDS generator: DC/saw/triangle/square/sine, amplitude scaling,
// config changes applied on accumulator wrap. DDS_PHASE_SYNC_EN adds sync_in (phase reset).
module dds_wavegen #(
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int OUT_W   = 8
) (
  input logic          clk,
  input logic          rst,
  dds_wavegen_if.slave bus
);

  localparam int QN    = 1 << (ADDR_W - 2);
  localparam int SH    = OUT_W - ADDR_W;
  localparam int PW    = 2 * OUT_W + 3;
  localparam int MID_I = 1 << (OUT_W - 1);
  localparam int FRAC  = 28;
  localparam longint PI_F = 64'd843314857;  // pi * 2^28

  localparam logic [OUT_W-1:0]         MID   = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0]        HALF  = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic signed [PW-1:0]     MID_S = {{(PW-OUT_W){1'b0}}, MID};
  localparam logic signed [PW-1:0]     MAX_S = {{(PW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  localparam logic [2:0] MODE_DC  = 3'd0;
  localparam logic [2:0] MODE_SAW = 3'd1;
  localparam logic [2:0] MODE_TRI = 3'd2;
  localparam logic [2:0] MODE_SQR = 3'd3;
  localparam logic [2:0] MODE_SIN = 3'd4;

  typedef enum logic {IDLE, PEND} state_t;

  typedef struct packed {
    logic [2:0]         mode;
    logic [PHASE_W-1:0] tune;
    logic [ADDR_W-1:0]  duty;
    logic [OUT_W-1:0]   amp;
    logic [ADDR_W-1:0]  phase;
  } cfg_t;

  localparam cfg_t CFG_RST = '{mode: MODE_DC, tune: '0, duty: HALF, amp: '1, phase: '0};

  // round((MID-1)*sin(i*pi/(2*QN))) via fixed-point Taylor series, elaboration only
  function automatic int sine_q(input int i);
    longint x, x2, term, s;
    x    = (longint'(i) * PI_F) / longint'(2 * QN);
    x2   = (x * x) >>> FRAC;
    term = x;
    s    = x;
    for (int k = 1; k <= 10; k++) begin
      term = -(((term * x2) >>> FRAC) / longint'((2 * k) * (2 * k + 1)));
      s    = s + term;
    end
    return int'(((s * longint'(MID_I - 1)) + (longint'(1) <<< (FRAC - 1))) >>> FRAC);
  endfunction

  // NOTE: the quarter-wave table is constant logic, not storage, so it has no reset.
  logic [OUT_W-2:0] sine_tab [QN+1];
  for (genvar g = 0; g <= QN; g++) begin : g_sine
    localparam logic [OUT_W-2:0] QV = (OUT_W-1)'(sine_q(g));
    assign sine_tab[g] = QV;
  end

  state_t             state;
  cfg_t               act, pend, cfg_in;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W:0]   acc_sum;
  logic               carry, sync, apply_evt;
  logic [ADDR_W-1:0]  addr;

  assign cfg_in = '{mode: bus.cfg_mode, tune: bus.cfg_tune, duty: bus.cfg_duty,
                    amp: bus.cfg_amp, phase: bus.cfg_phase};

`ifdef DDS_PHASE_SYNC_EN
  assign sync = bus.sync_in;
`else
  assign sync = 1'b0;
`endif

  assign acc_sum   = {1'b0, acc} + {1'b0, act.tune};
  assign carry     = acc_sum[PHASE_W];
  assign apply_evt = sync | (bus.en & carry);
  assign addr      = acc[PHASE_W-1 -: ADDR_W] + act.phase;

  // Active config swaps on the same edge the accumulator wraps, so the first
  // post-wrap sample already uses it.
  always_ff @(posedge clk or posedge rst) begin : p_ctrl
    // NOTE: every register here uses <= so all updates see pre-edge values.
    if (rst) begin
      acc      <= '0;
      bus.wrap <= 1'b0;
      state    <= IDLE;
      act      <= CFG_RST;
      pend     <= CFG_RST;
    end else begin
      if (sync) begin
        acc      <= '0;
        bus.wrap <= 1'b0;
      end else if (bus.en) begin
        acc      <= acc_sum[PHASE_W-1:0];
        bus.wrap <= carry;
      end else begin
        bus.wrap <= 1'b0;
      end

      if (bus.cfg_load) pend <= cfg_in;

      case (state)
        IDLE: begin
          if (bus.cfg_load) begin
            if (!bus.en) act <= cfg_in;
            else         state <= PEND;
          end
        end
        PEND: begin
          if (!bus.en) begin
            act   <= bus.cfg_load ? cfg_in : pend;
            state <= IDLE;
          end else if (apply_evt) begin
            act <= pend;
            if (!bus.cfg_load) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [ADDR_W-1:0] s1_addr, s1_duty;
  logic [2:0]        s1_mode;
  logic [OUT_W-1:0]  s1_amp, s2_amp, s2_raw, raw_n, sine_raw, pout_n;
  logic [1:0]        vld_sr;
  logic [1:0]        quad;
  logic [ADDR_W-3:0] qlow;
  logic [ADDR_W-2:0] qidx;
  logic [OUT_W-2:0]  mag;
  logic [ADDR_W-1:0] tri_val;

  assign quad     = s1_addr[ADDR_W-1 -: 2];
  assign qlow     = s1_addr[ADDR_W-3:0];
  assign qidx     = quad[0] ? ((ADDR_W-1)'(QN) - {1'b0, qlow}) : {1'b0, qlow};
  assign mag      = sine_tab[qidx];
  assign sine_raw = quad[1] ? (MID - {1'b0, mag}) : (MID + {1'b0, mag});
  assign tri_val  = s1_addr[ADDR_W-1] ? ~{s1_addr[ADDR_W-2:0], 1'b0}
                                      :  {s1_addr[ADDR_W-2:0], 1'b0};

  always_comb begin : p_raw
    // NOTE: default assignment first keeps this purely combinational (no latch).
    raw_n = MID;
    case (s1_mode)
      MODE_SAW: raw_n = OUT_W'(s1_addr) << SH;
      MODE_TRI: raw_n = OUT_W'(tri_val) << SH;
      MODE_SQR: raw_n = (s1_addr < s1_duty) ? '1 : '0;
      MODE_SIN: raw_n = sine_raw;
      default:  raw_n = MID;
    endcase
  end

  logic signed [OUT_W:0]   diff;
  logic signed [OUT_W+1:0] gain;
  logic signed [PW-1:0]    prod, scaled;

  assign diff   = $signed({1'b0, s2_raw}) - $signed({1'b0, MID});
  assign gain   = $signed({2'b00, s2_amp} + (OUT_W+2)'(1));
  assign prod   = PW'(diff) * PW'(gain);
  assign scaled = (prod >>> OUT_W) + MID_S;

  always_comb begin : p_clamp
    pout_n = scaled[OUT_W-1:0];
    if (scaled[PW-1])        pout_n = '0;
    else if (scaled > MAX_S) pout_n = '1;
  end

  // Per-sample config travels with the sample so a config swap never splits one.
  always_ff @(posedge clk or posedge rst) begin : p_pipe
    if (rst) begin
      s1_addr        <= '0;
      s1_mode        <= MODE_DC;
      s1_duty        <= HALF;
      s1_amp         <= '1;
      s2_raw         <= MID;
      s2_amp         <= '1;
      vld_sr         <= '0;
      bus.pout       <= MID;
      bus.pout_valid <= 1'b0;
    end else begin
      s1_addr        <= addr;
      s1_mode        <= act.mode;
      s1_duty        <= act.duty;
      s1_amp         <= act.amp;
      s2_raw         <= raw_n;
      s2_amp         <= s1_amp;
      vld_sr         <= {vld_sr[0], bus.en};
      bus.pout       <= pout_n;
      bus.pout_valid <= vld_sr[1];
    end
  end

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: per-cycle comparison against a behavioural
// model (real-valued sine, plain arithmetic) plus hand-computed literal points.
module tb_dds_wavegen;
  localparam int     PHASE_W = 32;
  localparam int     ADDR_W  = 8;
  localparam int     OUT_W   = 8;
  localparam longint TUNE    = 64'd1 << 24;
  localparam longint MODULUS = 64'd1 << 32;
  localparam real    PI      = 3.141592653589793;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dds_wavegen_if #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) bus ();

  dds_wavegen #(.PHASE_W(PHASE_W), .ADDR_W(ADDR_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  int cnt;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  typedef struct {
    int     mode;
    longint tune;
    int     duty;
    int     amp;
    int     phase;
  } mcfg_t;

  mcfg_t  m_act, m_pend;
  bit     m_pending;
  longint m_acc;
  bit     m_wrap;
  int     h[3];
  bit     vh[3];

  function automatic mcfg_t default_cfg();
    mcfg_t c;
    c.mode = 0; c.tune = 0; c.duty = 128; c.amp = 255; c.phase = 0;
    return c;
  endfunction

  // Sample value straight from the waveform definitions.
  function automatic int wave(input longint acc, input mcfg_t c);
    int  a, raw, d;
    real x;
    a = int'(((acc >> 24) + c.phase) % 256);
    case (c.mode)
      1: raw = a;
      2: raw = (a < 128) ? 2 * a : 255 - 2 * (a - 128);
      3: raw = (a < c.duty) ? 255 : 0;
      4: begin
        x   = 127.0 * $sin(2.0 * PI * a / 256.0);
        raw = 128 + ((x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x));
      end
      default: raw = 128;
    endcase
    d   = (raw - 128) * (c.amp + 1);
    d   = d >>> 8;
    raw = 128 + d;
    if (raw < 0)   raw = 0;
    if (raw > 255) raw = 255;
    return raw;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_wrap = 0; m_pending = 0;
    m_act = default_cfg(); m_pend = default_cfg();
    for (int i = 0; i < 3; i++) begin h[i] = 128; vh[i] = 0; end
  endtask

  task automatic model_step();
    mcfg_t  in;
    int     samp;
    longint nxt;
    bit     en, carry, sync, ld;
    en = bus.en; ld = bus.cfg_load;
    in.mode = int'(bus.cfg_mode); in.tune = longint'(bus.cfg_tune);
    in.duty = int'(bus.cfg_duty); in.amp = int'(bus.cfg_amp); in.phase = int'(bus.cfg_phase);
    samp = wave(m_acc, m_act);
    h[2] = h[1]; h[1] = h[0]; h[0] = samp;
    vh[2] = vh[1]; vh[1] = vh[0]; vh[0] = en;
    nxt   = m_acc + m_act.tune;
    carry = en && (nxt >= MODULUS);
    sync  = 1'b0;
`ifdef DDS_PHASE_SYNC_EN
    sync  = bus.sync_in;
`endif
    if (sync) begin m_acc = 0; m_wrap = 0; end
    else if (en) begin m_acc = nxt % MODULUS; m_wrap = carry; end
    else m_wrap = 0;
    if (!m_pending) begin
      if (ld) begin
        m_pend = in;
        if (en) m_pending = 1;
        else    m_act = in;
      end
    end else if (!en) begin
      if (ld) m_pend = in;
      m_act = m_pend; m_pending = 0;
    end else begin
      if (sync || carry) begin m_act = m_pend; m_pending = ld; end
      if (ld) m_pend = in;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("pout_model", bus.pout, h[2]);
      check("valid_model", bus.pout_valid, vh[2]);
      check("wrap_model", bus.wrap, m_wrap);
    end
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input int mode, input longint tune, input int duty, input int amp, input int phase);
    bus.cfg_mode  = 3'(mode);
    bus.cfg_tune  = 32'(tune);
    bus.cfg_duty  = 8'(duty);
    bus.cfg_amp   = 8'(amp);
    bus.cfg_phase = 8'(phase);
    bus.cfg_load  = 1'b1;
    @(negedge clk);
    bus.cfg_load  = 1'b0;
  endtask

  task automatic pulse_reset();
    bus.en = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.en = 0; bus.cfg_load = 0; bus.cfg_mode = 0; bus.cfg_tune = 0;
    bus.cfg_duty = 0; bus.cfg_amp = 0; bus.cfg_phase = 0;
`ifdef DDS_PHASE_SYNC_EN
    bus.sync_in = 0;
`endif
    run(2);
    check("rst_pout", bus.pout, 128);
    check("rst_valid", bus.pout_valid, 0);
    check("rst_wrap", bus.wrap, 0);
    rst = 1'b0;

    // Sine, full amplitude, one period per 256 clocks
    load(4, TUNE, 128, 255, 0);
    bus.en = 1'b1;
    run(2);  check("sin_valid_early", bus.pout_valid, 0);
    run(1);  check("sin_valid_first", bus.pout_valid, 1);
             check("sin_a0", bus.pout, 128);
    run(64); check("sin_a64", bus.pout, 255);
    run(64); check("sin_a128", bus.pout, 128);
    run(64); check("sin_a192", bus.pout, 1);
    run(61); check("sin_wrap1", bus.wrap, 1);
    run(1);  check("sin_wrap_pulse", bus.wrap, 0);
    run(255); check("sin_wrap2", bus.wrap, 1);

    // Reset while a config is pending
    load(1, TUNE, 128, 255, 0);
    #2 rst = 1'b1;
    #1;
    check("midrst_pout", bus.pout, 128);
    check("midrst_valid", bus.pout_valid, 0);
    check("midrst_wrap", bus.wrap, 0);
    @(negedge clk);
    rst = 1'b0;
    run(5);
    bus.en = 1'b0;
    run(10);
    check("pend_discarded", bus.pout, 128);

    // Triangle at half amplitude
    load(2, TUNE, 128, 127, 0);
    bus.en = 1'b1;
    run(3);   check("tri_a0", bus.pout, 64);
    run(128); check("tri_a128", bus.pout, 191);

    // Square duty 64, then duty 0 applied at the next wrap
    pulse_reset();
    load(3, TUNE, 64, 255, 0);
    bus.en = 1'b1;
    run(3);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.pout == 8'hFF) cnt++;
      run(1);
    end
    check("sq_high_count", cnt, 64);
    load(3, TUNE, 0, 255, 0);
    run(300);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      if (bus.pout == 8'h00) cnt++;
      run(1);
    end
    check("sq_duty0_zero_count", cnt, 256);

    // Glitch-free swap: saw runs to the wrap, last of two loads wins
    pulse_reset();
    load(1, TUNE, 128, 255, 0);
    bus.en = 1'b1;
    run(100);
    load(3, TUNE, 128, 255, 0);
    run(20);
    load(2, TUNE, 128, 255, 0);
    run(136); check("swap_last_saw", bus.pout, 255);
    run(1);   check("swap_tri_a0", bus.pout, 0);
    run(1);   check("swap_tri_a1", bus.pout, 2);

    // Undefined mode code behaves as DC
    bus.en = 1'b0;
    load(7, TUNE, 128, 255, 0);
    run(3);   check("mode7_dc", bus.pout, 128);

`ifdef DDS_PHASE_SYNC_EN
    pulse_reset();
    load(1, TUNE, 128, 255, 0);
    bus.en = 1'b1;
    run(100);
    bus.sync_in = 1'b1;
    run(1);
    bus.sync_in = 1'b0;
    check("sync_wrap", bus.wrap, 0);
    run(2);   check("sync_pre_a100", bus.pout, 100);
    run(1);   check("sync_a0", bus.pout, 0);
`endif

    bus.en = 1'b0;
    run(5);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
